rot_seq_6_bit: RTL
==================

Name: rot_seq_6_bit

Overview:
Iterative rotate sequencer for the 6-bit CPU datapath: accepts a rotate request (operand, amount, direction), performs it one bit position per clock, and returns the result with CPU flags (cf, sf, zf).
Sits between the instruction control unit and the register file write-back path.
Intended as the multi-cycle, area-lean counterpart of the single-cycle rotate unit, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 6, operand/result width; amount is reduced modulo WIDTH
CNT_W, 3, step counter width; must satisfy 2^CNT_W > WIDTH-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  request valid
start_ready  output  1  block can accept a request (high only in IDLE)
dir  input  1  0 = rotate left, 1 = rotate right
a  input  WIDTH  operand
b  input  WIDTH  rotate amount, unsigned, taken modulo WIDTH
cf_prev  input  1  current carry flag, passed through when amount mod WIDTH = 0
flush  input  1  synchronous abort to IDLE
res_valid  output  1  result valid
res_ready  input  1  consumer accepts result
r  output  WIDTH  rotated result (registered)
cf  output  1  carry flag (registered)
sf  output  1  sign flag = r[WIDTH-1]
zf  output  1  zero flag = (r == 0)
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; r = 0; cf = 0; count = 0; res_valid = 0.
  - start_ready = 1, busy = 0, sf = 0, zf = 1.
- States: IDLE, RUN, DONE. Encode as a 2-bit enum.
- IDLE:
  - start_ready = 1.
  - On start_valid && start_ready: latch a into r, n = b mod WIDTH into count, dir, and cf_prev into cf.
  - Next state is DONE if n == 0, otherwise RUN.
- RUN (one position per cycle):
  - rol: r <= {r[WIDTH-2:0], r[WIDTH-1]}; cf <= r[WIDTH-1].
  - ror: r <= {r[0], r[WIDTH-1:1]}; cf <= r[0].
  - count decrements each cycle. The step taken with count == 1 moves the state to DONE.
- cf result after n > 0 steps is the last bit rotated out:
  - rol: cf == final r[0].
  - ror: cf == final r[WIDTH-1].
- DONE:
  - res_valid = 1. r and cf are held stable until res_valid && res_ready, then the state returns to IDLE.
  - No new request is accepted in DONE, so accept and hand-off never happen in the same cycle.
- Latency: request accepted at edge T gives res_valid high from edge T+1+n, where n = b mod WIDTH (range 1..6 cycles).
- Throughput: one operation per (n + 2) cycles minimum.
- sf and zf are combinational from registered r. They are only meaningful while res_valid = 1.
- flush:
  - From RUN or DONE: next state IDLE, res_valid deasserts next cycle, and the partial r is discarded (r and cf keep their last values).
  - In IDLE: flush has priority over start_valid, and the request is not accepted.
- Reset asserted mid-RUN or in DONE: immediate return to the reset values above. No result is produced.
- Amount wrap: b = 6, 12, …, 60 behaves exactly like b = 0 (cf passes through cf_prev).
- b = 63 reduces to 3.
- res_ready held low: DONE persists indefinitely with outputs unchanged. start_ready stays 0.

Decomposition:
- Shared package `rot_pkg`:
  - state enum (IDLE/RUN/DONE),
  - direction constants ROT_L = 0 and ROT_R = 1,
  - WIDTH default 6.
- One sub-module, `rot_step_6_bit`: combinational single-position rotate. Inputs are value and dir; outputs are the rotated value and the bit rotated out.
- The FSM, counter and handshake stay in the top module.
- Modulo reduction is a constant-divisor operation on a 6-bit input. It is implemented as a small compare/subtract (b mod 6), not a generic divider.

Test Plan:
- rol, a=6'b100001, b=1, cf_prev=0 -> r=6'b000011, cf=1, sf=0, zf=0; res_valid exactly 2 cycles after accept.
- rol, a=6'b110000, b=8 (mod 6 = 2) -> r=6'b000011, cf=1; 2 RUN cycles, res_valid at T+3.
- rol, a=6'b101010, b=6, cf_prev=1 -> r=6'b101010, cf=1, sf=1; res_valid at T+1, no RUN cycles.
- ror, a=6'b000001, b=1 -> r=6'b100000, cf=1, sf=1; then ror, a=0, b=5 -> r=0, zf=1, cf=0.
- Handshake: hold res_ready low 4 cycles in DONE while pulsing start_valid -> r/cf/flags unchanged, start_ready=0, no second accept; raise res_ready -> IDLE next cycle, start_ready=1.
- Abort cases:
  - Assert flush during RUN (b=5, after 2 steps) -> IDLE next cycle, no res_valid.
  - Pull rst_n low mid-RUN -> all outputs at reset values asynchronously; a fresh request afterwards completes correctly.

Source files
------------

// File: rtl/rot_seq_6_bit_pkg.sv
// rtl/rot_seq_6_bit_pkg.sv - shared types and constants for the iterative rotate sequencer
package rot_pkg;

    localparam int ROT_WIDTH = 6;

    localparam logic ROT_L = 1'b0;
    localparam logic ROT_R = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rot_state_t;

endpackage

// File: rtl/rot_seq_6_bit_if.sv
// rtl/rot_seq_6_bit_if.sv - request/result handshake bundle for the rotate sequencer
interface rot_seq_6_bit_if #(
    parameter int WIDTH = rot_pkg::ROT_WIDTH
);
    logic             start_valid;
    logic             start_ready;
    logic             dir;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cf_prev;
    logic             flush;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] r;
    logic             cf;
    logic             sf;
    logic             zf;
    logic             busy;

    modport master (
        output start_valid, dir, a, b, cf_prev, flush, res_ready,
        input  start_ready, res_valid, r, cf, sf, zf, busy
    );

    modport slave (
        input  start_valid, dir, a, b, cf_prev, flush, res_ready,
        output start_ready, res_valid, r, cf, sf, zf, busy
    );
endinterface

// File: rtl/rot_seq_6_bit_step.sv
// rtl/rot_seq_6_bit_step.sv - combinational single-position rotate with bit-out
module rot_step_6_bit
    import rot_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic             dir,
    output logic [WIDTH-1:0] rotated,
    output logic             out_bit
);

    always_comb begin
        rotated = value;
        out_bit = 1'b0;
        if (dir == ROT_R) begin
            rotated = {value[0], value[WIDTH-1:1]};
            out_bit = value[0];
        end else begin
            rotated = {value[WIDTH-2:0], value[WIDTH-1]};
            out_bit = value[WIDTH-1];
        end
    end

endmodule

// File: rtl/rot_seq_6_bit.sv
// rtl/rot_seq_6_bit.sv - multi-cycle rotate sequencer, one bit position per clock
module rot_seq_6_bit
    import rot_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst_n,
    rot_seq_6_bit_if.slave  bus
);

    localparam logic [2*WIDTH-1:0] DIVISOR = (2*WIDTH)'(WIDTH);

    // Shift-and-subtract against WIDTH<<k; keeps the reduction a few comparators deep.
    function automatic logic [CNT_W-1:0] mod_width(input logic [WIDTH-1:0] v);
        logic [2*WIDTH-1:0] rem;
        rem = {{WIDTH{1'b0}}, v};
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (rem >= (DIVISOR << k)) begin
                rem = rem - (DIVISOR << k);
            end
        end
        return rem[CNT_W-1:0];
    endfunction

    rot_state_t       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             cf_q, cf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] step_val;
    logic             step_bit;

    assign amount = mod_width(bus.b);

    rot_step_6_bit #(
        .WIDTH(WIDTH)
    ) u_step (
        .value  (r_q),
        .dir    (dir_q),
        .rotated(step_val),
        .out_bit(step_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            cf_q    <= 1'b0;
            count_q <= '0;
            dir_q   <= ROT_L;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cf_q    <= cf_d;
            count_q <= count_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cf_d    = cf_q;
        count_d = count_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                // flush outranks a pending request
                if (!bus.flush && bus.start_valid) begin
                    r_d     = bus.a;
                    cf_d    = bus.cf_prev;
                    count_d = amount;
                    dir_d   = bus.dir;
                    state_d = (amount == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    r_d     = step_val;
                    cf_d    = step_bit;
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.flush || bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.start_ready = (state_q == ST_IDLE);
    assign bus.res_valid   = (state_q == ST_DONE);
    assign bus.busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign bus.r           = r_q;
    assign bus.cf          = cf_q;
    assign bus.sf          = r_q[WIDTH-1];
    assign bus.zf          = (r_q == '0);

endmodule
